// File: rtl/msu_pkg.sv
`default_nettype none
// ============================================================================
// msu_pkg : controller state encoding, stream sizing helpers      rev 1.0
// ============================================================================
package msu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_EMIT  = 3'd5,
    ST_DRAIN = 3'd6,
    ST_DONE  = 3'd7
  } msu_state_e;

  // Input job: t_start, t_final, ckpt_interval, then the squaring operand.
  function automatic int in_words(int axi_len, int t_len, int sq_bits);
    return (3 * t_len) / axi_len + sq_bits / axi_len;
  endfunction

  // Output frame: t_current, then the result.
  function automatic int out_words(int axi_len, int t_len, int sq_bits);
    return t_len / axi_len + sq_bits / axi_len;
  endfunction

  function automatic bit widths_ok(int axi_len, int t_len, int sq_bits);
    return (axi_len >= 32) && ((axi_len & (axi_len - 1)) == 0) &&
           (t_len % axi_len == 0) && (sq_bits % axi_len == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msu_ckpt_ctrl_out_buf.sv
`default_nettype none
// ============================================================================
// msu_out_buf : single-frame output shift register for the AXI-stream master
// rev 1.0
// ============================================================================
module msu_out_buf #(
  parameter int AXI_LEN   = 64,
  parameter int OUT_WORDS = 17
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         load,
  input  logic [OUT_WORDS*AXI_LEN-1:0] load_data,
  input  logic                         load_user,
  output logic                         empty,
  output logic                         tvalid,
  input  logic                         tready,
  output logic [AXI_LEN-1:0]           tdata,
  output logic                         tlast,
  output logic                         tuser
);

  localparam int OUT_BITS = OUT_WORDS * AXI_LEN;
  localparam int CNT_W    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(OUT_WORDS - 1);

  logic [OUT_BITS-1:0] r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_valid;
  logic                r_user;
  logic                w_beat;

  assign w_beat = r_valid & tready;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_user  <= 1'b0;
    end else if (load && !r_valid) begin
      r_sr    <= load_data;
      r_user  <= load_user;
      r_valid <= 1'b1;
      r_cnt   <= '0;
    end else if (w_beat) begin
      // Word 0 always sits at the bottom; the remainder slides down per beat.
      r_sr <= {{AXI_LEN{1'b0}}, r_sr[OUT_BITS-1:AXI_LEN]};
      if (r_cnt == C_LAST) begin
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign empty  = !r_valid;
  assign tvalid = r_valid;
  assign tdata  = r_sr[AXI_LEN-1:0];
  assign tlast  = r_valid && (r_cnt == C_LAST);
  assign tuser  = r_user;

endmodule
`default_nettype wire

// File: rtl/msu_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// msu_ckpt_ctrl : modular-squaring controller with checkpoint frame output
// rev 1.0
// ============================================================================
module msu_ckpt_ctrl
  import msu_pkg::*;
#(
  parameter int AXI_LEN           = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int SQ_BITS           = 1024,
  parameter int T_LEN             = 64,
  parameter int CKPT_EN           = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ap_start,
  input  logic                         abort,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [AXI_LEN-1:0]           s_axis_tdata,
  output logic [C_XFER_SIZE_WIDTH-1:0] s_axis_xfer_size_in_bytes,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [AXI_LEN-1:0]           m_axis_tdata,
  output logic [AXI_LEN/8-1:0]         m_axis_tkeep,
  output logic                         m_axis_tuser,
  output logic [C_XFER_SIZE_WIDTH-1:0] m_axis_xfer_size_in_bytes,
  output logic                         sq_start,
  output logic [SQ_BITS-1:0]           sq_in,
  input  logic [SQ_BITS-1:0]           sq_out,
  input  logic                         sq_valid,
  output logic                         ap_done,
  output logic                         ap_err
);

  localparam int IN_WORDS  = in_words(AXI_LEN, T_LEN, SQ_BITS);
  localparam int OUT_WORDS = out_words(AXI_LEN, T_LEN, SQ_BITS);
  localparam int IN_BITS   = IN_WORDS * AXI_LEN;
  localparam int OUT_BITS  = OUT_WORDS * AXI_LEN;
  localparam int IN_CNT_W  = $clog2(IN_WORDS);
  localparam logic [IN_CNT_W-1:0] C_IN_LAST = IN_CNT_W'(IN_WORDS - 1);

  if (!widths_ok(AXI_LEN, T_LEN, SQ_BITS)) begin : g_bad_widths
    $error("msu_ckpt_ctrl: illegal AXI_LEN / T_LEN / SQ_BITS combination");
  end

  msu_state_e           r_state;
  logic [IN_BITS-1:0]   r_in_sr;
  logic [IN_CNT_W-1:0]  r_in_cnt;
  logic [T_LEN-1:0]     r_t_cur;
  logic [T_LEN-1:0]     r_iter_cnt;
  logic [SQ_BITS-1:0]   r_operand;
  logic                 r_final;
  logic                 r_s_tready;
  logic                 r_sq_start;
  logic                 r_ap_done;
  logic                 r_ap_err;

  logic [T_LEN-1:0]     w_t_start;
  logic [T_LEN-1:0]     w_t_final;
  logic [T_LEN-1:0]     w_interval;
  logic [SQ_BITS-1:0]   w_sq_init;
  logic [T_LEN-1:0]     w_t_next;
  logic                 w_ckpt_hit;
  logic                 w_buf_empty;
  logic                 w_buf_load;

  // The input shift register doubles as the job-parameter store once loaded.
  assign w_t_start  = r_in_sr[T_LEN-1:0];
  assign w_t_final  = r_in_sr[2*T_LEN-1:T_LEN];
  assign w_interval = r_in_sr[3*T_LEN-1:2*T_LEN];
  assign w_sq_init  = r_in_sr[3*T_LEN +: SQ_BITS];
  assign w_t_next   = r_t_cur + T_LEN'(1);

  if (CKPT_EN != 0) begin : g_ckpt
    assign w_ckpt_hit = (w_interval != '0) && ((r_iter_cnt + T_LEN'(1)) == w_interval);
  end else begin : g_no_ckpt
    assign w_ckpt_hit = 1'b0;
  end

  assign w_buf_load = (r_state == ST_EMIT) && w_buf_empty;

  always_ff @(posedge clk) begin
    if (!reset_n || abort) begin
      r_state    <= ST_IDLE;
      r_in_cnt   <= '0;
      r_final    <= 1'b0;
      r_s_tready <= 1'b0;
      r_sq_start <= 1'b0;
      r_ap_done  <= 1'b0;
      r_ap_err   <= 1'b0;
    end else begin
      r_sq_start <= 1'b0;
      r_ap_done  <= 1'b0;
      r_ap_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ap_start) begin
            r_state    <= ST_RECV;
            r_s_tready <= 1'b1;
            r_in_cnt   <= '0;
          end
        end
        ST_RECV: begin
          if (s_axis_tvalid) begin
            r_in_sr  <= {s_axis_tdata, r_in_sr[IN_BITS-1:AXI_LEN]};
            r_in_cnt <= r_in_cnt + 1'b1;
            if (r_in_cnt == C_IN_LAST) begin
              r_s_tready <= 1'b0;
              r_state    <= ST_LOAD;
            end else if (s_axis_tlast) begin
              r_s_tready <= 1'b0;
              r_ap_err   <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_LOAD: begin
          r_t_cur    <= w_t_start;
          r_iter_cnt <= '0;
          r_operand  <= w_sq_init;
          if (w_t_start == w_t_final) begin
            r_final <= 1'b1;
            r_state <= ST_EMIT;
          end else begin
            r_sq_start <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (sq_valid) begin
            r_t_cur   <= w_t_next;
            r_operand <= sq_out;
            // Final iteration outranks a coinciding checkpoint.
            if (w_t_next == w_t_final) begin
              r_final <= 1'b1;
              r_state <= ST_EMIT;
            end else if (w_ckpt_hit) begin
              r_final    <= 1'b0;
              r_iter_cnt <= '0;
              r_state    <= ST_EMIT;
            end else begin
              r_iter_cnt <= r_iter_cnt + T_LEN'(1);
              r_sq_start <= 1'b1;
              r_state    <= ST_ISSUE;
            end
          end
        end
        ST_EMIT: begin
          if (w_buf_empty) begin
            if (r_final) begin
              r_state <= ST_DRAIN;
            end else begin
              r_sq_start <= 1'b1;
              r_state    <= ST_ISSUE;
            end
          end
        end
        ST_DRAIN: begin
          if (w_buf_empty) begin
            r_ap_done <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  msu_out_buf #(
    .AXI_LEN   (AXI_LEN),
    .OUT_WORDS (OUT_WORDS)
  ) u_out_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort),
    .load      (w_buf_load),
    .load_data (OUT_BITS'({r_operand, r_t_cur})),
    .load_user (r_final),
    .empty     (w_buf_empty),
    .tvalid    (m_axis_tvalid),
    .tready    (m_axis_tready),
    .tdata     (m_axis_tdata),
    .tlast     (m_axis_tlast),
    .tuser     (m_axis_tuser)
  );

  assign s_axis_tready             = r_s_tready;
  assign sq_start                  = r_sq_start;
  assign sq_in                     = r_operand;
  assign ap_done                   = r_ap_done;
  assign ap_err                    = r_ap_err;
  assign m_axis_tkeep              = '1;
  assign s_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(IN_WORDS * AXI_LEN / 8);
  assign m_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(OUT_WORDS * AXI_LEN / 8);

endmodule
`default_nettype wire

// File: tb/tb_msu_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// tb_msu_ckpt_ctrl : directed, table-driven bench for msu_ckpt_ctrl  rev 1.0
// ============================================================================
module tb_msu_ckpt_ctrl;

  localparam int AW = 64;
  localparam int IW = 19;
  localparam int OW = 17;

  logic            clk;
  logic            reset_n;
  logic            ap_start;
  logic            abort;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [AW-1:0]   s_tdata;
  logic [31:0]     s_xfer;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [AW-1:0]   m_tdata;
  logic [AW/8-1:0] m_tkeep;
  logic            m_tuser;
  logic [31:0]     m_xfer;
  logic            sq_start;
  logic [1023:0]   sq_in;
  logic [1023:0]   sq_out;
  logic            sq_valid;
  logic            ap_done;
  logic            ap_err;

  msu_ckpt_ctrl dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .ap_start                  (ap_start),
    .abort                     (abort),
    .s_axis_tvalid             (s_tvalid),
    .s_axis_tready             (s_tready),
    .s_axis_tlast              (s_tlast),
    .s_axis_tdata              (s_tdata),
    .s_axis_xfer_size_in_bytes (s_xfer),
    .m_axis_tvalid             (m_tvalid),
    .m_axis_tready             (m_tready),
    .m_axis_tlast              (m_tlast),
    .m_axis_tdata              (m_tdata),
    .m_axis_tkeep              (m_tkeep),
    .m_axis_tuser              (m_tuser),
    .m_axis_xfer_size_in_bytes (m_xfer),
    .sq_start                  (sq_start),
    .sq_in                     (sq_in),
    .sq_out                    (sq_out),
    .sq_valid                  (sq_valid),
    .ap_done                   (ap_done),
    .ap_err                    (ap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act[767:0], exp[767:0]);
    end
  endtask

  function automatic logic [1023:0] pw(input logic [1023:0] x, input int n);
    for (int i = 0; i < n; i++) x = x * x;
    return x;
  endfunction

  // Squarer model: result appears 3 cycles after sq_start.
  logic [1023:0] sq_x;
  int            sq_cd = 0;
  initial begin sq_valid = 1'b0; sq_out = '0; end
  always @(negedge clk) begin
    sq_valid = 1'b0;
    if (sq_cd > 0) begin
      sq_cd--;
      if (sq_cd == 0) begin
        sq_out   = sq_x * sq_x;
        sq_valid = 1'b1;
      end
    end
    if (sq_start) begin
      sq_x  = sq_in;
      sq_cd = 3;
    end
  end

  // Output monitor: frame assembly, tlast/tuser rules, stall stability, event counts.
  logic [63:0]        q_t[$];
  logic [1023:0]      q_res[$];
  logic               q_user[$];
  int                 mon_idx = 0;
  logic [OW*AW-1:0]   mon_buf;
  logic               mon_user;
  int                 n_beats = 0, n_starts = 0, n_done = 0, n_err = 0;
  logic [AW-1:0]      held_d;
  logic               held_u;
  bit                 stalled = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_tvalid && m_tready) begin
        if (mon_idx == 0) mon_user = m_tuser;
        else chk("tuser_const", m_tuser, mon_user);
        chk("tlast_pos", m_tlast, mon_idx == OW - 1);
        mon_buf[mon_idx*AW +: AW] = m_tdata;
        n_beats++;
        if (mon_idx == OW - 1) begin
          q_t.push_back(mon_buf[63:0]);
          q_res.push_back(mon_buf[OW*AW-1:AW]);
          q_user.push_back(mon_user);
          mon_idx = 0;
        end else begin
          mon_idx++;
        end
      end
      if (m_tvalid && !m_tready) begin
        if (stalled) begin
          chk("stall_tdata", m_tdata, held_d);
          chk("stall_tuser", m_tuser, held_u);
        end
        held_d  = m_tdata;
        held_u  = m_tuser;
        stalled = 1;
      end else begin
        stalled = 0;
      end
      if (sq_start) n_starts++;
      if (ap_done)  n_done++;
      if (ap_err)   n_err++;
    end
  end

  task automatic send_job(input logic [63:0] ts, input logic [63:0] tf, input logic [63:0] iv,
                          input logic [1023:0] sq, input int n_send, input int tlast_at);
    logic [IW*AW-1:0] w;
    w = {sq, iv, tf, ts};
    ap_start = 1'b1;
    for (int i = 0; i < n_send; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = w[i*AW +: AW];
      s_tlast  = (i == tlast_at);
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (s_tready) break;
      end
      @(posedge clk); #1;
      ap_start = 1'b0;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int c = 0; c < 5000; c++) begin
      if (n_done != d0) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    chk("ap_done_count", n_done - d0, 1);
  endtask

  typedef struct {
    logic [63:0]   ts;
    logic [63:0]   tf;
    logic [63:0]   iv;
    logic [1023:0] sq;
    int            frames;
    int            starts;
    logic [1023:0] res;
  } job_t;

  job_t jobs[5];

  task automatic run_table_job(input int k);
    int s0, d0;
    logic [63:0]   t_exp;
    logic [1023:0] r_exp;
    bit            last;
    q_t.delete(); q_res.delete(); q_user.delete();
    s0 = n_starts;
    d0 = n_done;
    send_job(jobs[k].ts, jobs[k].tf, jobs[k].iv, jobs[k].sq, IW, (k % 2 == 0) ? IW - 1 : -1);
    wait_done(d0);
    chk($sformatf("job%0d_frames", k), q_t.size(), jobs[k].frames);
    chk($sformatf("job%0d_starts", k), n_starts - s0, jobs[k].starts);
    for (int f = 0; f < jobs[k].frames && f < q_t.size(); f++) begin
      last  = (f == jobs[k].frames - 1);
      t_exp = last ? jobs[k].tf : jobs[k].ts + 64'(f + 1) * jobs[k].iv;
      r_exp = last ? jobs[k].res : pw(jobs[k].sq, (f + 1) * int'(jobs[k].iv));
      chk($sformatf("job%0d_f%0d_t", k, f), q_t[f], t_exp);
      chk($sformatf("job%0d_f%0d_res", k, f), q_res[f], r_exp);
      chk($sformatf("job%0d_f%0d_user", k, f), q_user[f], last);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0]   st_t[3];
    logic [1023:0] st_r[3];
    int s0, d0, e0, b0;

    // {ts, tf, iv, sq, frames, sq_starts, final result}
    jobs[0] = '{64'd0,  64'd3,  64'd0, 1024'd2,     1, 3, 1024'd256};
    jobs[1] = '{64'd10, 64'd10, 64'd0, 1024'd12345, 1, 0, 1024'd12345};
    jobs[2] = '{64'd0,  64'd7,  64'd3, 1024'd2,     3, 7, 1024'd1 << 128};
    jobs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1024'd5, 1, 2, 1024'd625};
    jobs[4] = '{64'd0,  64'd6,  64'd3, 1024'd2,     2, 6, 1024'd1 << 64};

    reset_n = 1'b0; ap_start = 1'b0; abort = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_sq_start", sq_start, 0);
    chk("rst_ap_done",  ap_done,  0);
    chk("rst_ap_err",   ap_err,   0);
    chk("s_xfer_size",  s_xfer,   152);
    chk("m_xfer_size",  m_xfer,   136);
    chk("m_tkeep",      m_tkeep,  8'hFF);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    for (int k = 0; k < 5; k++) run_table_job(k);

    // Back-pressure: interval 1, sink stalls for 100 cycles after the first beat.
    q_t.delete(); q_res.delete(); q_user.delete();
    s0 = n_starts; d0 = n_done; b0 = n_beats;
    send_job(64'd0, 64'd3, 64'd1, 1024'd3, IW, IW - 1);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (n_beats != b0) break;
    end
    @(posedge clk); #1;
    m_tready = 1'b0;
    chk("stall_first_beat", n_beats != b0, 1);
    repeat (100) @(posedge clk);
    #1;
    chk("stall_starts", n_starts - s0, 2);
    chk("stall_tvalid", m_tvalid, 1);
    m_tready = 1'b1;
    wait_done(d0);
    st_t = '{64'd1, 64'd2, 64'd3};
    st_r = '{1024'd9, 1024'd81, 1024'd6561};
    chk("stall_frames", q_t.size(), 3);
    chk("stall_total_starts", n_starts - s0, 3);
    for (int f = 0; f < 3 && f < q_t.size(); f++) begin
      chk($sformatf("stall_f%0d_t", f), q_t[f], st_t[f]);
      chk($sformatf("stall_f%0d_res", f), q_res[f], st_r[f]);
      chk($sformatf("stall_f%0d_user", f), q_user[f], f == 2);
    end

    // Abort in the middle of the output frame.
    q_t.delete(); q_res.delete(); q_user.delete();
    d0 = n_done;
    send_job(64'd0, 64'd3, 64'd0, 1024'd2, IW, IW - 1);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (mon_idx == 5) break;
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_tvalid", m_tvalid, 0);
    @(posedge clk); #1;
    mon_idx = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_frame", q_t.size(), 0);
    chk("abort_s_tready", s_tready, 0);
    run_table_job(0);

    // Early tlast on the third input beat.
    s0 = n_starts; e0 = n_err;
    send_job(64'd0, 64'd3, 64'd0, 1024'd2, 3, 2);
    repeat (10) @(posedge clk);
    #1;
    chk("err_pulse", n_err - e0, 1);
    chk("err_no_start", n_starts - s0, 0);
    chk("err_s_tready", s_tready, 0);
    chk("err_m_tvalid", m_tvalid, 0);
    run_table_job(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msu_ckpt_ctrl.md
Name: msu_ckpt_ctrl

Overview:
- Next-generation modular-squaring-unit controller with AXI-stream in/out.
- Loads t_start, t_final, a checkpoint interval and the squaring operand, then iterates an external squarer one iteration at a time.
- Emits intermediate checkpoint frames every N iterations and a final frame; stalls the squarer under output back-pressure.
- Sits between the host DMA streams and the modular_square core; it does not instantiate the core.

Parameters:
AXI_LEN, 64, stream data width in bits; power of two, >=32
C_XFER_SIZE_WIDTH, 32, width of the xfer-size outputs
SQ_BITS, 1024, squarer operand/result width; SQ_BITS % AXI_LEN == 0
T_LEN, 64, iteration-counter width; T_LEN % AXI_LEN == 0
CKPT_EN, 1, 0 removes checkpoint logic; only the final frame is emitted

Ports:
clk  in  1  clock
reset_n  in  1  synchronous reset, active-low
ap_start  in  1  level; starts a job when in IDLE
abort  in  1  pulse; cancels the current job
s_axis_tvalid/tready/tlast  in/out/in  1  input stream handshake
s_axis_tdata  in  AXI_LEN  input words
s_axis_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  constant, IN_WORDS*AXI_LEN/8
m_axis_tvalid/tready/tlast  out/in/out  1  output stream handshake
m_axis_tdata  out  AXI_LEN  output words
m_axis_tkeep  out  AXI_LEN/8  all ones
m_axis_tuser  out  1  1 = final frame, 0 = checkpoint; constant across a frame
m_axis_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  constant, OUT_WORDS*AXI_LEN/8
sq_start  out  1  one-cycle pulse; sq_in is valid with it
sq_in  out  SQ_BITS  operand
sq_out  in  SQ_BITS  result
sq_valid  in  1  one-cycle pulse; result valid
ap_done  out  1  one-cycle pulse on job completion
ap_err  out  1  one-cycle pulse on framing error

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: state IDLE; all handshake outputs, sq_start, ap_done and ap_err low; output buffer marked empty.
- Word counts:
  - IN_WORDS = 3*T_LEN/AXI_LEN + SQ_BITS/AXI_LEN.
  - Input order: t_start, t_final, ckpt_interval, sq_in; each field least-significant word first.
  - OUT_WORDS = T_LEN/AXI_LEN + SQ_BITS/AXI_LEN.
  - Output order: t_current, then result; each field least-significant word first.
- States:
  - IDLE: goes to RECV when ap_start is high.
  - RECV: s_axis_tready=1. Each accepted beat increments the word counter.
    - Counter reaches IN_WORDS: go to LOAD.
    - tlast accepted before the final word: pulse ap_err, go to IDLE.
    - tlast absent on the final word: ignored.
  - LOAD: latch the fields; t_current=t_start; iter_cnt=0.
    - If t_start==t_final: the frame is result=sq_in, tuser=1; go to EMIT.
    - Otherwise go to ISSUE.
  - ISSUE: pulse sq_start with the operand; go to WAIT.
  - WAIT: on sq_valid, t_current+=1 (wraps modulo 2^T_LEN), iter_cnt+=1, operand<=sq_out.
    - If t_current+1==t_final: final frame, go to EMIT.
    - Else if CKPT_EN, ckpt_interval!=0 and iter_cnt+1==ckpt_interval: checkpoint frame, iter_cnt<=0, go to EMIT.
    - Otherwise go to ISSUE.
  - EMIT: hold here while the output buffer is busy (this stalls the squarer).
    - When the buffer is empty, capture {t_current, result, tuser} in one cycle.
    - Final frame: go to DRAIN. Checkpoint frame: go to ISSUE.
  - DRAIN: wait for the buffer to empty, then go to DONE.
  - DONE: pulse ap_done; go to IDLE.
- Output buffer:
  - Single-entry shift register with its own word counter; runs concurrently with ISSUE/WAIT.
  - m_axis_tvalid=1 while non-empty; shifts one word per tvalid&tready beat.
  - tlast on word OUT_WORDS-1; empty the cycle after that beat.
  - tdata and tuser stable while tvalid&!tready.
- Latency:
  - ISSUE to sq_start: 0 cycles.
  - sq_valid to next sq_start: 2 cycles if the buffer is empty; otherwise until the buffer empties +1.
- abort or reset_n low in any state:
  - Next state IDLE; output buffer flushed; m_axis_tvalid low next cycle, even mid-frame.
  - A later stale sq_valid is ignored in IDLE and RECV.
  - ap_done is not pulsed.
- Simultaneous events:
  - abort beats ap_start and sq_valid.
  - A checkpoint coinciding with the final iteration emits only the final frame.

Decomposition:
- Package msu_pkg holds:
  - the state enum;
  - IN_WORDS/OUT_WORDS functions of (AXI_LEN, T_LEN, SQ_BITS);
  - an elaboration-time width check.
- Sub-module msu_out_buf (parametrised shift register, word counter, tlast/tuser generation) is natural.
- The input shift register stays inline.

Test Plan:
- AXI_LEN=64, t_start=0, t_final=3, interval=0, sq_in=2, squarer model x^2 mod 2^1024 -> exactly one frame: 17 beats, t_current=3, result=256, tuser=1, tlast on beat 17, ap_done once.
- t_start=10, t_final=10 -> no sq_start; one frame with t_current=10, result=sq_in, tuser=1.
- t_final=7, interval=3 -> two checkpoint frames (t=3, t=6, tuser=0), then the final frame at t=7; results match the model; 7 sq_start pulses.
- interval=1, m_axis_tready held low 100 cycles after the first beat -> no sq_start while the buffer is full; tdata held stable; all frames arrive in order once tready rises.
- abort mid-frame (beat 5) -> tvalid low next cycle, no ap_done; a second job then completes correctly.
- tlast on input beat 3 -> ap_err pulse, return to IDLE; t_start=2^64-1 with t_final=1 wraps and terminates after 2 iterations.
